sat_bin_host_ctrl: RTL



---
 rtl/sat_bin_host_pkg.sv | 27 ++
 rtl/sat_bin_host_ctrl_ex_addr_cnt.sv | 49 ++++
 rtl/sat_bin_host_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/sat_bin_host_pkg.sv
// Shared encodings for the sat_bin host-side sequencer: command opcodes and FSM states.
package sat_bin_host_pkg;

    localparam logic [2:0] OP_WR_V   = 3'd0;
    localparam logic [2:0] OP_WR_C   = 3'd1;
    localparam logic [2:0] OP_WR_VS  = 3'd2;
    localparam logic [2:0] OP_WR_LS  = 3'd3;
    localparam logic [2:0] OP_SET_NV = 3'd4;
    localparam logic [2:0] OP_SET_NB = 3'd5;
    localparam logic [2:0] OP_GO     = 3'd6;
    localparam logic [2:0] OP_RSVD   = 3'd7;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_LOAD   = 3'd1;
    localparam state_t ST_INFO   = 3'd2;
    localparam state_t ST_START  = 3'd3;
    localparam state_t ST_RUN    = 3'd4;
    localparam state_t ST_RESULT = 3'd5;

    // Ops 0..3 are the four RAM write targets.
    function automatic logic is_write_op(input logic [2:0] op);
        return (op[2] == 1'b0);
    endfunction

endpackage

// File: rtl/sat_bin_host_ctrl_ex_addr_cnt.sv
// Per-target auto-increment write address with a sticky full flag; writes past the last
// address are dropped and reported instead of wrapping.
module ex_addr_cnt #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  wr,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  drop
);

    logic [ADDR_WIDTH-1:0] cnt;
    logic                  full;
    logic [ADDR_WIDTH-1:0] cnt_eff;
    logic                  full_eff;

    // A clear in the same cycle as a write makes that write land at address 0.
    assign cnt_eff  = clr ? '0 : cnt;
    assign full_eff = clr ? 1'b0 : full;
    assign drop     = wr && full_eff;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            full <= 1'b0;
            we   <= 1'b0;
            addr <= '0;
        end else begin
            we <= wr && !full_eff;
            if (wr && !full_eff) begin
                addr <= cnt_eff;
                if (cnt_eff == '1) begin
                    cnt  <= cnt_eff;
                    full <= 1'b1;
                end else begin
                    cnt  <= cnt_eff + 1'b1;
                    full <= 1'b0;
                end
            end else begin
                cnt  <= cnt_eff;
                full <= full_eff;
            end
        end
    end

endmodule

// File: rtl/sat_bin_host_ctrl.sv
// Host command sequencer for sat_bin: loads the four RAMs over the external ports,
// then strobes bin info, starts the solver, times the run and holds the result until acked.
module sat_bin_host_ctrl
    import sat_bin_host_pkg::*;
#(
    parameter int WIDTH_VAR        = 12,
    parameter int WIDTH_CLAUSES    = 16,
    parameter int WIDTH_VAR_STATES = 19,
    parameter int WIDTH_LVL_STATES = 11,
    parameter int ADDR_WIDTH       = 10,
    parameter int WIDTH_DATA       = 19,
    parameter int WIDTH_CYC        = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cmd_valid_i,
    output logic                        cmd_ready_o,
    input  logic [2:0]                  cmd_op_i,
    input  logic [WIDTH_DATA-1:0]       cmd_data_i,
    output logic                        apply_ex_o,
    output logic                        ram_we_v_o,
    output logic                        ram_we_c_o,
    output logic                        ram_we_vs_o,
    output logic                        ram_we_ls_o,
    output logic [WIDTH_VAR-1:0]        ram_din_v_o,
    output logic [WIDTH_CLAUSES-1:0]    ram_din_c_o,
    output logic [WIDTH_VAR_STATES-1:0] ram_din_vs_o,
    output logic [WIDTH_LVL_STATES-1:0] ram_din_ls_o,
    output logic [ADDR_WIDTH-1:0]       ram_addr_v_o,
    output logic [ADDR_WIDTH-1:0]       ram_addr_c_o,
    output logic [ADDR_WIDTH-1:0]       ram_addr_vs_o,
    output logic [ADDR_WIDTH-1:0]       ram_addr_ls_o,
    output logic                        bin_info_en_o,
    output logic [WIDTH_VAR-1:0]        nv_all_o,
    output logic [WIDTH_CLAUSES-1:0]    nb_all_o,
    output logic                        start_o,
    input  logic                        done_i,
    input  logic                        global_sat_i,
    input  logic                        global_unsat_i,
    output logic                        res_valid_o,
    output logic                        res_sat_o,
    output logic                        res_unsat_o,
    output logic [WIDTH_CYC-1:0]        res_cycles_o,
    input  logic                        res_ack_i,
    output logic                        busy_o,
    output logic                        err_o
);

    state_t               state;
    state_t               state_nx;
    logic                 ready_q;
    logic                 accept;
    logic                 clr_cnt;
    logic                 wr_v, wr_c, wr_vs, wr_ls;
    logic                 drop_v, drop_c, drop_vs, drop_ls;
    logic [WIDTH_CYC-1:0] cyc;

    assign accept  = cmd_valid_i && ready_q;
    assign clr_cnt = accept && (state == ST_IDLE) && is_write_op(cmd_op_i);
    assign wr_v    = accept && (cmd_op_i == OP_WR_V);
    assign wr_c    = accept && (cmd_op_i == OP_WR_C);
    assign wr_vs   = accept && (cmd_op_i == OP_WR_VS);
    assign wr_ls   = accept && (cmd_op_i == OP_WR_LS);

    assign cmd_ready_o   = ready_q;
    assign apply_ex_o    = ready_q;
    assign busy_o        = (state != ST_IDLE) && (state != ST_LOAD);
    assign bin_info_en_o = (state == ST_INFO);
    assign start_o       = (state == ST_START);
    assign res_valid_o   = (state == ST_RESULT);

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE, ST_LOAD: begin
                if (accept) begin
                    if (is_write_op(cmd_op_i)) begin
                        state_nx = ST_LOAD;
                    end else if (cmd_op_i == OP_GO) begin
                        state_nx = ST_INFO;
                    end
                end
            end
            ST_INFO:   state_nx = ST_START;
            ST_START:  state_nx = ST_RUN;
            ST_RUN:    if (done_i) state_nx = ST_RESULT;
            ST_RESULT: if (res_ack_i) state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    // Ready/apply are registered from the next state so both stay low through reset
    // and rise on the first edge after release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            ready_q <= 1'b0;
        end else begin
            state   <= state_nx;
            ready_q <= (state_nx == ST_IDLE) || (state_nx == ST_LOAD);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            nv_all_o     <= '0;
            nb_all_o     <= '0;
            ram_din_v_o  <= '0;
            ram_din_c_o  <= '0;
            ram_din_vs_o <= '0;
            ram_din_ls_o <= '0;
            err_o        <= 1'b0;
        end else begin
            if (accept && (cmd_op_i == OP_SET_NV)) nv_all_o <= cmd_data_i[WIDTH_VAR-1:0];
            if (accept && (cmd_op_i == OP_SET_NB)) nb_all_o <= cmd_data_i[WIDTH_CLAUSES-1:0];
            if (wr_v)  ram_din_v_o  <= cmd_data_i[WIDTH_VAR-1:0];
            if (wr_c)  ram_din_c_o  <= cmd_data_i[WIDTH_CLAUSES-1:0];
            if (wr_vs) ram_din_vs_o <= cmd_data_i[WIDTH_VAR_STATES-1:0];
            if (wr_ls) ram_din_ls_o <= cmd_data_i[WIDTH_LVL_STATES-1:0];
            if ((accept && (cmd_op_i == OP_RSVD)) || drop_v || drop_c || drop_vs || drop_ls) begin
                err_o <= 1'b1;
            end
        end
    end

    // Run timer saturates rather than wrapping so a hung solver reads as "very long".
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc          <= '0;
            res_sat_o    <= 1'b0;
            res_unsat_o  <= 1'b0;
            res_cycles_o <= '0;
        end else if (state == ST_START) begin
            cyc <= '0;
        end else if (state == ST_RUN) begin
            if (done_i) begin
                res_sat_o    <= global_sat_i;
                res_unsat_o  <= global_unsat_i;
                res_cycles_o <= cyc;
            end else if (cyc != '1) begin
                cyc <= cyc + 1'b1;
            end
        end
    end

    ex_addr_cnt #(.ADDR_WIDTH(ADDR_WIDTH)) u_cnt_v (
        .clk(clk), .rst(rst), .clr(clr_cnt), .wr(wr_v),
        .we(ram_we_v_o), .addr(ram_addr_v_o), .drop(drop_v)
    );

    ex_addr_cnt #(.ADDR_WIDTH(ADDR_WIDTH)) u_cnt_c (
        .clk(clk), .rst(rst), .clr(clr_cnt), .wr(wr_c),
        .we(ram_we_c_o), .addr(ram_addr_c_o), .drop(drop_c)
    );

    ex_addr_cnt #(.ADDR_WIDTH(ADDR_WIDTH)) u_cnt_vs (
        .clk(clk), .rst(rst), .clr(clr_cnt), .wr(wr_vs),
        .we(ram_we_vs_o), .addr(ram_addr_vs_o), .drop(drop_vs)
    );

    ex_addr_cnt #(.ADDR_WIDTH(ADDR_WIDTH)) u_cnt_ls (
        .clk(clk), .rst(rst), .clr(clr_cnt), .wr(wr_ls),
        .we(ram_we_ls_o), .addr(ram_addr_ls_o), .drop(drop_ls)
    );

endmodule
